// File: rtl/lcd_wr_if.sv
// Handshake and pin bundle between the LCD write engine and its source/pad logic.
interface lcd_wr_if #(
  parameter int unsigned DW    = 16,
  parameter int unsigned LEN_W = 17
) ();
  logic             start_i;
  logic             mode_i;
  logic [LEN_W-1:0] len_i;
  logic             abort_i;
  logic [DW-1:0]    src_data_i;
  logic             src_dc_i;
  logic             fetch_o;
  logic             lcd_cs_n;
  logic             lcd_wr_n;
  logic             lcd_dc;
  logic [DW-1:0]    lcd_data;
  logic             mode_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, mode_i, len_i, abort_i, src_data_i, src_dc_i,
    input  fetch_o, lcd_cs_n, lcd_wr_n, lcd_dc, lcd_data, mode_o, busy_o, done_o
  );

  modport slave (
    input  start_i, mode_i, len_i, abort_i, src_data_i, src_dc_i,
    output fetch_o, lcd_cs_n, lcd_wr_n, lcd_dc, lcd_data, mode_o, busy_o, done_o
  );
endinterface

// File: rtl/lcd_wr_engine.sv
// 8080-style parallel LCD write engine: programmable setup/strobe timing, bursts with abort.
// Optional macro LCD_WR_WORDCNT_EN adds a saturating 32-bit written-word counter (wr_cnt_o).
module lcd_wr_engine #(
  parameter int unsigned DW      = 16,
  parameter int unsigned LEN_W   = 17,
  parameter int unsigned T_SETUP = 1,
  parameter int unsigned T_WRL   = 2,
  parameter int unsigned T_WRH   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  lcd_wr_if.slave     bus
`ifdef LCD_WR_WORDCNT_EN
  ,
  output logic [31:0] wr_cnt_o
`endif
);

  localparam int unsigned T_MAX01 = (T_SETUP > T_WRL) ? T_SETUP : T_WRL;
  localparam int unsigned T_MAX   = (T_MAX01 > T_WRH) ? T_MAX01 : T_WRH;
  localparam int unsigned CNT_W   = $clog2(T_MAX + 1);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    SETUP = 5'b00010,
    WR_L  = 5'b00100,
    WR_H  = 5'b01000,
    NEXT  = 5'b10000
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             pend_q, pend_d;
  logic             mode_q, mode_d;
  logic [DW-1:0]    data_q, data_d;
  logic             dc_q, dc_d;
  logic             cs_n_q, cs_n_d;
  logic             wr_n_q, wr_n_d;
  logic             fetch_q, fetch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and registered-output logic; every word entry reloads data and D/C.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    data_d  = data_q;
    dc_d    = dc_q;
    cs_n_d  = cs_n_q;
    wr_n_d  = wr_n_q;
    fetch_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (bus.start_i) begin
          if (bus.len_i != '0) begin
            state_d = SETUP;
            cnt_d   = '0;
            mode_d  = bus.mode_i;
            rem_d   = bus.len_i;
            data_d  = bus.src_data_i;
            dc_d    = bus.mode_i ? 1'b1 : bus.src_dc_i;
            cs_n_d  = 1'b0;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      SETUP: begin
        if (bus.abort_i) pend_d = 1'b1;
        if (cnt_q == CNT_W'(T_SETUP - 1)) begin
          state_d = WR_L;
          cnt_d   = '0;
          wr_n_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WR_L: begin
        if (bus.abort_i) pend_d = 1'b1;
        if (cnt_q == CNT_W'(T_WRL - 1)) begin
          state_d = WR_H;
          cnt_d   = '0;
          wr_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WR_H: begin
        if (bus.abort_i) pend_d = 1'b1;
        if (cnt_q == CNT_W'(T_WRH - 1)) begin
          state_d = NEXT;
          cnt_d   = '0;
          fetch_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      NEXT: begin
        rem_d = rem_q - LEN_W'(1);
        // An abort seen here only takes effect at the following word boundary.
        if (rem_q == LEN_W'(1) || pend_q) begin
          state_d = IDLE;
          pend_d  = 1'b0;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          if (bus.abort_i) pend_d = 1'b1;
          state_d = SETUP;
          cnt_d   = '0;
          data_d  = bus.src_data_i;
          dc_d    = mode_q ? 1'b1 : bus.src_dc_i;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      pend_q  <= 1'b0;
      mode_q  <= 1'b0;
      data_q  <= '0;
      dc_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      fetch_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      fetch_q <= fetch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.fetch_o  = fetch_q;
  assign bus.lcd_cs_n = cs_n_q;
  assign bus.lcd_wr_n = wr_n_q;
  assign bus.lcd_dc   = dc_q;
  assign bus.lcd_data = data_q;
  assign bus.mode_o   = mode_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;

`ifdef LCD_WR_WORDCNT_EN
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Cleared by every accepted start, saturating count of fetch pulses.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (state_q == IDLE && bus.start_i) begin
      wr_cnt_d = '0;
    end else if (fetch_q && wr_cnt_q != '1) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wr_cnt_q <= '0;
    else       wr_cnt_q <= wr_cnt_d;
  end

  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_wr_engine.sv
// Bench for lcd_wr_engine: two instances (default timing and 3/1/4 timing) checked every cycle
// against a burst-timeline model, plus literal timing pins.
module tb_lcd_wr_engine;
  localparam int TS0 = 1, TL0 = 2, TH0 = 2;
  localparam int TS1 = 3, TL1 = 1, TH1 = 4;

  typedef struct packed {
    logic        cs;
    logic        wr;
    logic        dc;
    logic        fetch;
    logic        busy;
    logic        done;
    logic        mode;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  lcd_wr_if #(.DW(16), .LEN_W(17)) b0 ();
  lcd_wr_if #(.DW(16), .LEN_W(17)) b1 ();
`ifdef LCD_WR_WORDCNT_EN
  logic [31:0] wc0, wc1;
`endif

  lcd_wr_engine #(.DW(16), .LEN_W(17), .T_SETUP(TS0), .T_WRL(TL0), .T_WRH(TH0)) dut0 (
    .clk(clk), .rstn(rstn), .bus(b0)
`ifdef LCD_WR_WORDCNT_EN
    , .wr_cnt_o(wc0)
`endif
  );
  lcd_wr_engine #(.DW(16), .LEN_W(17), .T_SETUP(TS1), .T_WRL(TL1), .T_WRH(TH1)) dut1 (
    .clk(clk), .rstn(rstn), .bus(b1)
`ifdef LCD_WR_WORDCNT_EN
    , .wr_cnt_o(wc1)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int idx [2] = '{0, 0};
  logic [15:0] mem [2][64];
  logic        dcm [2][64];

  // Source: presents the next word while fetch_o is high, advances on the edge that ends it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b0.fetch_o) idx[0] <= idx[0] + 1;
    if (b1.fetch_o) idx[1] <= idx[1] + 1;
  end
  assign b0.src_data_i = mem[0][6'(idx[0] + int'(b0.fetch_o))];
  assign b0.src_dc_i   = dcm[0][6'(idx[0] + int'(b0.fetch_o))];
  assign b1.src_data_i = mem[1][6'(idx[1] + int'(b1.fetch_o))];
  assign b1.src_dc_i   = dcm[1][6'(idx[1] + int'(b1.fetch_o))];

  // Model: one burst timeline per instance.
  bit          has   [2] = '{0, 0};
  int          base  [2] = '{0, 0};
  int          nw    [2] = '{0, 0};
  int          idx0  [2] = '{0, 0};
  int          zdone [2] = '{-1, -1};
  bit          mmode [2] = '{0, 0};
  bit          pdc   [2] = '{0, 0};
  bit          pmode [2] = '{0, 0};
  logic [15:0] pdata [2] = '{16'h0, 16'h0};

  function automatic int ts(int i);  return (i == 0) ? TS0 : TS1; endfunction
  function automatic int tl(int i);  return (i == 0) ? TL0 : TL1; endfunction
  function automatic int per(int i); return (i == 0) ? TS0 + TL0 + TH0 + 1 : TS1 + TL1 + TH1 + 1; endfunction

  function automatic exp_t model_exp(int i, int c);
    exp_t e;
    int k, w, p, a;
    e.cs = 1'b1; e.wr = 1'b1; e.fetch = 1'b0; e.busy = 1'b0;
    e.done = (c == zdone[i]); e.data = pdata[i]; e.dc = pdc[i]; e.mode = pmode[i];
    if (has[i] && c >= base[i]) begin
      e.mode = mmode[i];
      k = c - base[i];
      if (k < nw[i] * per(i)) begin
        w = k / per(i);
        p = k % per(i);
        e.cs = 1'b0; e.busy = 1'b1;
        e.wr = !(p >= ts(i) && p < ts(i) + tl(i));
        e.fetch = (p == per(i) - 1);
      end else begin
        w = nw[i] - 1;
        e.done = e.done | (k == nw[i] * per(i));
      end
      a = (idx0[i] + w) % 64;
      e.data = mem[i][a];
      e.dc = mmode[i] ? 1'b1 : dcm[i][a];
    end
    return e;
  endfunction

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", nm, i, cyc, act, exp);
    end
  endtask

  // Observed-event counters used by the literal pins.
  int   falls [2] = '{0, 0};
  int   lows  [2] = '{0, 0};
  int   fets  [2] = '{0, 0};
  int   lfall [2] = '{0, 0};
  int   pfall [2] = '{0, 0};
  int   ldone [2] = '{-1, -1};
  int   lchg  [2] = '{0, 0};
  logic pwr   [2] = '{1'b1, 1'b1};
  logic [15:0] pdat [2] = '{16'h0, 16'h0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e, a;
      if (i == 0) begin
        a.cs = b0.lcd_cs_n; a.wr = b0.lcd_wr_n; a.dc = b0.lcd_dc; a.fetch = b0.fetch_o;
        a.busy = b0.busy_o; a.done = b0.done_o; a.mode = b0.mode_o; a.data = b0.lcd_data;
      end else begin
        a.cs = b1.lcd_cs_n; a.wr = b1.lcd_wr_n; a.dc = b1.lcd_dc; a.fetch = b1.fetch_o;
        a.busy = b1.busy_o; a.done = b1.done_o; a.mode = b1.mode_o; a.data = b1.lcd_data;
      end
      if (rstn) e = model_exp(i, cyc);
      else      e = '{cs: 1'b1, wr: 1'b1, dc: 1'b0, fetch: 1'b0, busy: 1'b0, done: 1'b0, mode: 1'b0, data: 16'h0};
      chk("cs_n", i, 32'(a.cs), 32'(e.cs));
      chk("wr_n", i, 32'(a.wr), 32'(e.wr));
      chk("dc", i, 32'(a.dc), 32'(e.dc));
      chk("fetch", i, 32'(a.fetch), 32'(e.fetch));
      chk("busy", i, 32'(a.busy), 32'(e.busy));
      chk("done", i, 32'(a.done), 32'(e.done));
      chk("mode_o", i, 32'(a.mode), 32'(e.mode));
      chk("data", i, 32'(a.data), 32'(e.data));
      if (!a.wr && pwr[i]) begin falls[i]++; pfall[i] = lfall[i]; lfall[i] = cyc; end
      if (!a.wr) lows[i]++;
      if (a.fetch) fets[i]++;
      if (a.done) ldone[i] = cyc;
      if (a.data != pdat[i]) lchg[i] = cyc;
      pwr[i] = a.wr;
      pdat[i] = a.data;
    end
  end

  task automatic waitc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drv(int i, bit st, int len, bit md, bit ab);
    if (i == 0) begin
      b0.start_i = st; b0.len_i = 17'(len); b0.mode_i = md; b0.abort_i = ab;
    end else begin
      b1.start_i = st; b1.len_i = 17'(len); b1.mode_i = md; b1.abort_i = ab;
    end
  endtask

  task automatic load(int i, logic [15:0] d0, logic [15:0] d1, logic [15:0] d2, logic [15:0] d3,
                      logic [3:0] dcs);
    logic [15:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int j = 0; j < 4; j++) begin
      mem[i][(idx[i] + j) % 64] = d[j];
      dcm[i][(idx[i] + j) % 64] = dcs[j];
    end
  endtask

  // Called just after a rising edge; returns the SETUP-entry cycle of the requested burst.
  task automatic do_start(int i, int len, bit md, output int b);
    exp_t e;
    if (!has[i] || (cyc - base[i]) >= nw[i] * per(i)) begin
      if (len == 0) begin
        zdone[i] = cyc + 1;
      end else begin
        e = model_exp(i, cyc);
        pdata[i] = e.data; pdc[i] = e.dc; pmode[i] = e.mode;
        has[i] = 1'b1; base[i] = cyc + 1; nw[i] = len; mmode[i] = md; idx0[i] = idx[i];
      end
    end
    b = cyc + 1;
    drv(i, 1'b1, len, md, 1'b0);
    waitc(1);
    drv(i, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_abort(int i);
    int k, w, p, lim;
    if (has[i] && cyc >= base[i] && (cyc - base[i]) < nw[i] * per(i)) begin
      k = cyc - base[i];
      w = k / per(i);
      p = k % per(i);
      lim = (p == per(i) - 1) ? w + 2 : w + 1;
      if (lim < nw[i]) nw[i] = lim;
    end
    drv(i, 1'b0, 0, 1'b0, 1'b1);
    waitc(1);
    drv(i, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      has[i] = 1'b0; zdone[i] = -1; pdata[i] = 16'h0; pdc[i] = 1'b0; pmode[i] = 1'b0;
    end
  endtask

  initial begin
    int b, sf, sl, sfe, s;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 64; j++) begin
        mem[i][j] = 16'(j * 16'h0101);
        dcm[i][j] = 1'(j);
      end
    rstn = 1'b0;
    drv(0, 1'b0, 0, 1'b0, 1'b0);
    drv(1, 1'b0, 0, 1'b0, 1'b0);
    waitc(3);
    chk("rst_cs_lit", 0, 32'(b0.lcd_cs_n), 32'd1);
    chk("rst_busy_lit", 0, 32'(b0.busy_o), 32'd0);
    rstn = 1'b1;
    waitc(2);

    // Color burst of three words at default timing.
    load(0, 16'h1234, 16'h5678, 16'h9ABC, 16'h0000, 4'b0000);
    sf = falls[0]; sl = lows[0]; sfe = fets[0];
    do_start(0, 3, 1'b1, b);
    waitc(20);
    chk("t1_strobes", 0, 32'(falls[0] - sf), 32'd3);
    chk("t1_low_cycles", 0, 32'(lows[0] - sl), 32'd6);
    chk("t1_fetches", 0, 32'(fets[0] - sfe), 32'd3);
    chk("t1_spacing", 0, 32'(lfall[0] - pfall[0]), 32'd6);
    chk("t1_done_lat", 0, 32'(ldone[0] - b), 32'd18);
    chk("t1_last_data", 0, 32'(b0.lcd_data), 32'h9ABC);
`ifdef LCD_WR_WORDCNT_EN
    chk("t1_wr_cnt", 0, wc0, 32'd3);
`endif

    // Init-mode burst: D/C follows the source (0 then 1).
    load(0, 16'h00AA, 16'h00BB, 16'h0000, 16'h0000, 4'b0010);
    do_start(0, 2, 1'b0, b);
    waitc(1);
    chk("t2_dc_word0", 0, 32'(b0.lcd_dc), 32'd0);
    waitc(6);
    chk("t2_dc_word1", 0, 32'(b0.lcd_dc), 32'd1);
    waitc(8);
    chk("t2_mode_o", 0, 32'(b0.mode_o), 32'd0);

    // Abort during WR_L of the second word of four.
    load(0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0000);
    sf = falls[0]; sfe = fets[0];
    do_start(0, 4, 1'b1, b);
    waitc(7);
    do_abort(0);
    waitc(20);
    chk("t3_strobes", 0, 32'(falls[0] - sf), 32'd2);
    chk("t3_fetches", 0, 32'(fets[0] - sfe), 32'd2);
    chk("t3_done_cyc", 0, 32'(ldone[0] - b), 32'd12);
    chk("t3_cs_high", 0, 32'(b0.lcd_cs_n), 32'd1);

    // Zero-length burst.
    sf = falls[0]; sfe = fets[0];
    s = cyc;
    do_start(0, 0, 1'b0, b);
    waitc(3);
    chk("t4_done_cyc", 0, 32'(ldone[0] - s), 32'd1);
    chk("t4_strobes", 0, 32'(falls[0] - sf), 32'd0);
    chk("t4_fetches", 0, 32'(fets[0] - sfe), 32'd0);
`ifdef LCD_WR_WORDCNT_EN
    chk("t4_wr_cnt", 0, wc0, 32'd0);
`endif

    // Start re-pulsed while busy is ignored.
    load(0, 16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0, 4'b0000);
    sf = falls[0]; sfe = fets[0];
    do_start(0, 2, 1'b1, b);
    waitc(3);
    do_start(0, 4, 1'b0, s);
    waitc(16);
    chk("t5_strobes", 0, 32'(falls[0] - sf), 32'd2);
    chk("t5_fetches", 0, 32'(fets[0] - sfe), 32'd2);

    // Reset in the middle of WR_L.
    do_start(0, 4, 1'b1, b);
    waitc(1);
    chk("t5_in_wrl", 0, 32'(b0.lcd_wr_n), 32'd0);
    rstn = 1'b0;
    model_reset();
    #1;
    chk("rst_wr_n", 0, 32'(b0.lcd_wr_n), 32'd1);
    chk("rst_cs_n", 0, 32'(b0.lcd_cs_n), 32'd1);
    chk("rst_busy", 0, 32'(b0.busy_o), 32'd0);
    waitc(1);
    rstn = 1'b1;
    waitc(2);

    // Non-default timing instance: 3/1/4.
    load(1, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 4'b0000);
    sf = falls[1]; sl = lows[1];
    do_start(1, 2, 1'b1, b);
    waitc(22);
    chk("t6_strobes", 1, 32'(falls[1] - sf), 32'd2);
    chk("t6_low_cycles", 1, 32'(lows[1] - sl), 32'd2);
    chk("t6_period", 1, 32'(lfall[1] - pfall[1]), 32'd9);
    chk("t6_setup", 1, 32'(lfall[1] - lchg[1]), 32'd3);
    chk("t6_done_lat", 1, 32'(ldone[1] - b), 32'd18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_wr_engine.md
# lcd_wr_engine

Parametrised 8080-style parallel write engine for the LCD path. It is the successor of the fixed-timing write controller and sits between the init-table and framebuffer sources and the LCD pins. It adds configurable bus width, programmable setup, strobe-low and strobe-high cycle counts, a burst length with early abort, chip-select generation and per-word D/C control. It streams `len_i` words per burst, issuing one `fetch_o` pulse per word so the source advances its address.

## Interface
- `DW`, 16: LCD data bus width; legal values are 8, 9, 16 and 18.
- `LEN_W`, 17: width of the burst length field.
- `T_SETUP`, 1: cycles data and D/C are stable before `wr_n` falls; must be 1 or more.
- `T_WRL`, 2: cycles `wr_n` is held low; must be 1 or more.
- `T_WRH`, 2: cycles `wr_n` is held high after the rising edge (hold); must be 1 or more.
- `clk  in  1  system clock`
- `rstn  in  1  reset, asynchronous, active-low`
- `start_i  in  1  single-cycle burst request; sampled only in IDLE`
- `mode_i  in  1  0 = init (D/C from source), 1 = color (D/C forced 1); latched at start`
- `len_i  in  LEN_W  number of words in the burst; latched at start`
- `abort_i  in  1  finish the current word, then end the burst`
- `src_data_i  in  DW  current source word`
- `src_dc_i  in  1  D/C bit of the current source word`
- `fetch_o  out  1  one-cycle pulse: source must advance to the next word`
- `lcd_cs_n  out  1  chip select, active low`
- `lcd_wr_n  out  1  write strobe, active low`
- `lcd_dc  out  1  0 = command, 1 = data`
- `lcd_data  out  DW  bus data`
- `mode_o  out  1  latched mode`
- `busy_o  out  1  high from the cycle after start is accepted until return to IDLE`
- `done_o  out  1  one-cycle pulse at the end of a burst`

## Operation
- All outputs are registered.
- Reset values: `lcd_cs_n`=1, `lcd_wr_n`=1, `lcd_dc`=0, `lcd_data`=0, `fetch_o`=0, `mode_o`=0, `busy_o`=0, `done_o`=0. The FSM resets to IDLE.
- The FSM has five one-hot states: IDLE, SETUP, WR_L, WR_H, NEXT. One shared cycle counter is sized to hold the maximum of the three `T_*` values.
- **IDLE:**
  - On `start_i` with `len_i`≠0: latch `mode_i` and `len_i` into the remaining count `rem`, then go to SETUP.
  - On `start_i` with `len_i`=0: pulse `done_o` on the next cycle and stay in IDLE. `lcd_cs_n` stays 1.
- **SETUP entry:**
  - Latch `src_data_i` into `lcd_data`.
  - Set `lcd_dc` to `src_dc_i` in init mode, or to 1 in color mode.
  - Drive `lcd_cs_n`=0.
  - Stay T_SETUP cycles, then go to WR_L.
- **WR_L:** `lcd_wr_n`=0 for T_WRL cycles, then go to WR_H.
- **WR_H:** `lcd_wr_n`=1 for T_WRH cycles; `lcd_data` and `lcd_dc` are held. Then go to NEXT.
- **NEXT (1 cycle):**
  - `fetch_o`=1 and `rem` decrements.
  - If `rem`==1 or abort is pending: go to IDLE, pulse `done_o` and drive `lcd_cs_n`=1 on entry.
  - Otherwise go to SETUP.
- The source must present the next word within one cycle of `fetch_o`; it is sampled on SETUP entry.
- `fetch_o` pulses for every word written, including the last.
- **Abort:**
  - `abort_i` is sampled in SETUP, WR_L and WR_H and sets a sticky pending flag, cleared in IDLE.
  - An abort never truncates a strobe: the current word completes fully.
  - `abort_i` in IDLE or NEXT is ignored, except that an abort raised in the same cycle as NEXT is honoured at the next NEXT.
- `start_i` while busy is ignored; no queueing.
- `lcd_data`/`lcd_dc` are not altered in IDLE and keep the last word.
- **Reset mid-burst:** outputs return immediately to their reset values, with no `done_o`.

## Timing
- `start_i` sampled high at edge N means SETUP is entered at N+1 and `lcd_wr_n` falls at N+1+T_SETUP.
- Word period is T_SETUP+T_WRL+T_WRH+1 cycles; with the defaults that is 6 cycles.
- `done_o` is asserted in the same cycle that `busy_o` drops and `lcd_cs_n` rises.
- A burst of L words takes L·(T_SETUP+T_WRL+T_WRH+1) cycles from SETUP entry to IDLE.

## Configuration
- `LCD_WR_WORDCNT_EN`:
  - Defined: adds port `wr_cnt_o` (out, 32 bits). It resets to 0, clears on each accepted `start_i`, increments on every `fetch_o`, and saturates at 2^32−1.
  - Undefined: the port and counter are absent and all other behaviour is identical.

## Test plan
- Defaults; start, mode=1, len=3, data 0x1234/0x5678/0x9ABC → 3 `wr_n` low pulses of 2 cycles each, 6-cycle spacing; `lcd_dc`=1 throughout; 3 `fetch_o` pulses; `done_o` 18 cycles after SETUP entry.
- mode=0, len=2, dc sequence 0,1 → `lcd_dc` reads 0 during the first strobe and 1 during the second; `mode_o`=0.
- len=4 with `abort_i` pulsed during WR_L of word 2 → exactly 2 full strobes and 2 fetches, then `done_o`; `lcd_cs_n` rises.
- len=0 → no strobe, no fetch, `lcd_cs_n` stays 1, `done_o` one cycle after start; with the macro, `wr_cnt_o`=0.
- `start_i` re-pulsed while busy → ignored, the burst length is unchanged; assert `rstn` mid-WR_L → `lcd_wr_n`=1, `lcd_cs_n`=1 and `busy_o`=0 immediately.
- T_SETUP=3, T_WRL=1, T_WRH=4 → strobe falls 3 cycles after data change, low for 1 cycle, 9-cycle word period.
